regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of the 32x32 RegisterFile between two writeback requesters: the ALU path (A) and the load/store path (B). Each requester pushes `{rd, data}` into its own small FIFO through a valid/ready handshake. A round-robin arbiter drains one entry per cycle into a registered `wen/rd/din` stage that drives the RegisterFile directly. The block also reports pending-write hazards on the two read addresses for the issue stage, and discards writes to x0.

## Interface
- `DEPTH`, 2: entries per requester FIFO; power of two, at least 2.
- `XLEN`, 32: data width.
- `AW`, 5: register address width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `a_valid`  in  1: ALU write request.
- `a_ready`  out  1: A FIFO can accept.
- `a_rd`  in  AW: A destination register.
- `a_data`  in  XLEN: A write data.
- `b_valid`, `b_ready`, `b_rd`, `b_data`: same as the A ports, for the load/store requester.
- `wen`  out  1: RegisterFile write enable (registered).
- `rd`  out  AW: RegisterFile write address (registered).
- `din`  out  XLEN: RegisterFile write data (registered).
- `rs1`, `rs2`  in  AW: read addresses being issued.
- `rs1_busy`, `rs2_busy`  out  1: a write to that register is still pending.
- `idle`  out  1: both FIFOs are empty and `wen` is 0.

## Operation
**Reset.**
- FIFO pointers and counts clear to 0.
- `wen`=0, `rd`=0, `din`=0.
- `last_grant`=B, so A wins the first tie.
- `a_ready`=`b_ready`=0 while `rst` is high.
- Busy outputs are 0 and `idle`=1.

**Handshake.**
- `x_ready` = !full(x) && !rst. It does not depend on `x_valid`.
- A transfer occurs when `x_valid && x_ready`.
- A push is blocked when the FIFO is full, even if that FIFO is popped in the same cycle.

**x0 writes.**
- A transfer with `x_rd`==0 completes the handshake normally.
- The entry is not enqueued and never produces `wen`.

**Arbitration (each cycle).**
- Neither FIFO non-empty: `wen` is 0 next cycle.
- Exactly one FIFO non-empty: pop it.
- Both FIFOs non-empty: pop the requester other than `last_grant`, then update `last_grant`.
- The popped entry is registered: `wen`=1, `rd`, `din` on the next edge.
- Exactly one pop per cycle, at most.

**FIFO behaviour.**
- Push and pop on the same FIFO in one cycle are allowed when it is not full.
- Pointers wrap modulo `DEPTH`. The count disambiguates full from empty.

**Ordering.**
- FIFO order is preserved within a requester.
- There is no ordering between A and B writes to the same `rd`. The issue stage must use the busy outputs to prevent WAW hazards across requesters.

**Busy.**
- `rsN_busy` = (rsN != 0) && (rsN matches any occupied entry of either FIFO, or the output stage has `wen`=1 with `rd`==rsN).
- Purely combinational from state and `rsN`. It does not see same-cycle pushes.

**`idle`.** Combinational from state.

## Timing
- **Latency.** A request accepted at edge k with its FIFO previously empty and no contention gives `wen`=1 during cycle k+1 to k+2. The RegisterFile writes at edge k+2.
- **Throughput.** One write per cycle total. Under continuous contention each requester gets 1 of every 2 cycles.
- **`wen` duration.** `wen` is a one-cycle pulse per entry. Back-to-back entries keep it high continuously.
- **Busy window.** Busy rises the cycle after acceptance and clears in the cycle after the `wen` pulse for that entry.
- **Reset mid-operation.** Reset takes effect immediately and asynchronously:
  - `wen` drops to 0.
  - Queued entries are discarded.
  - No write is issued after release.
- **After reset release.** `ready` rises in the first cycle after `rst` deasserts.

## Test plan
- **Single write.** A pushes `rd`=10, data 0xBABEFACE at edge k -> `wen`=1, `rd`=10, `din`=0xBABEFACE exactly during cycle k+1; `idle` returns to 1 afterwards.
- **Tie arbitration.** A and B valid every cycle with distinct `rd` -> output alternates A, B, A, B, …, starting with A; `wen` high continuously; each FIFO's data appears in its own push order.
- **Full FIFO.** A and B valid for 8 consecutive cycles (`DEPTH`=2) -> `a_ready`/`b_ready` drop when count=2; every accepted entry is written exactly once; nothing is written that was not accepted.
- **x0 write.** A pushes `rd`=0, data 0x12345678 -> handshake completes; `wen` stays 0; `rs1`=0 gives `rs1_busy`=0.
- **Hazard window.** B pushes `rd`=2 at edge k with `rs1`=2 -> `rs1_busy`=1 in cycles k and k+1 (through the `wen` cycle), 0 from edge k+2; `rs2`=10 gives `rs2_busy`=0 throughout.
- **Reset mid-operation.** Assert `rst` with 2 entries queued and `wen`=1 -> `wen`=0 immediately, `ready`=0 during reset, `idle`=1; after release no `wen` pulse occurs until a new push.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the issue stage and the
// RegisterFile write port.
interface regfile_write_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;

  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;

  logic            wen;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] din;

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            idle;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output rs1, rs2,
    input  a_ready, b_ready,
    input  wen, rd, din,
    input  rs1_busy, rs2_busy, idle
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  rs1, rs2,
    output a_ready, b_ready,
    output wen, rd, din,
    output rs1_busy, rs2_busy, idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter: per-requester FIFOs, round-robin drain
// into a registered RegisterFile write stage, plus pending-write hazard flags.
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // Index 0 is requester A, index 1 is requester B.
  logic [AW-1:0]   mem_rd_q   [2][DEPTH];
  logic [XLEN-1:0] mem_data_q [2][DEPTH];
  logic [PW-1:0]   wptr_q [2];
  logic [PW-1:0]   rptr_q [2];
  logic [PW:0]     cnt_q  [2];

  grant_e          last_q, last_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] din_q, din_d;

  logic            in_valid [2];
  logic [AW-1:0]   in_rd    [2];
  logic [XLEN-1:0] in_data  [2];

  logic            full     [2];
  logic            nonempty [2];
  logic            ready    [2];
  logic            push     [2];
  logic            pop      [2];

  logic [PW-1:0]   off;
  logic            occ;
  logic            hit1, hit2;

  assign in_valid[0] = bus.a_valid;
  assign in_rd[0]    = bus.a_rd;
  assign in_data[0]  = bus.a_data;
  assign in_valid[1] = bus.b_valid;
  assign in_rd[1]    = bus.b_rd;
  assign in_data[1]  = bus.b_data;

  // x0 writes complete the handshake but are never enqueued.
  always_comb begin
    for (int unsigned r = 0; r < 2; r++) begin
      full[r]     = (cnt_q[r] == (PW+1)'(DEPTH));
      nonempty[r] = (cnt_q[r] != '0);
      ready[r]    = !full[r] && !rst;
      push[r]     = in_valid[r] && ready[r] && (in_rd[r] != '0);
    end
  end

  always_comb begin
    pop[0] = 1'b0;
    pop[1] = 1'b0;
    last_d = last_q;
    wen_d  = 1'b0;
    rd_d   = rd_q;
    din_d  = din_q;
    if (nonempty[0] && (!nonempty[1] || last_q == GRANT_B)) begin
      pop[0] = 1'b1;
      last_d = GRANT_A;
      wen_d  = 1'b1;
      rd_d   = mem_rd_q[0][rptr_q[0]];
      din_d  = mem_data_q[0][rptr_q[0]];
    end else if (nonempty[1]) begin
      pop[1] = 1'b1;
      last_d = GRANT_B;
      wen_d  = 1'b1;
      rd_d   = mem_rd_q[1][rptr_q[1]];
      din_d  = mem_data_q[1][rptr_q[1]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 2; r++) begin
        wptr_q[r] <= '0;
        rptr_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      last_q <= GRANT_B;
      wen_q  <= 1'b0;
      rd_q   <= '0;
      din_q  <= '0;
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        if (push[r]) wptr_q[r] <= wptr_q[r] + PW'(1);
        if (pop[r])  rptr_q[r] <= rptr_q[r] + PW'(1);
        cnt_q[r] <= cnt_q[r] + (PW+1)'(push[r]) - (PW+1)'(pop[r]);
      end
      last_q <= last_d;
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      din_q  <= din_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < 2; r++) begin
      if (push[r]) begin
        mem_rd_q[r][wptr_q[r]]   <= in_rd[r];
        mem_data_q[r][wptr_q[r]] <= in_data[r];
      end
    end
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    off  = '0;
    occ  = 1'b0;
    hit1 = wen_q && (rd_q == bus.rs1);
    hit2 = wen_q && (rd_q == bus.rs2);
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rptr_q[r];
        occ = ({1'b0, off} < cnt_q[r]);
        if (occ && (mem_rd_q[r][i] == bus.rs1)) hit1 = 1'b1;
        if (occ && (mem_rd_q[r][i] == bus.rs2)) hit2 = 1'b1;
      end
    end
  end

  assign bus.a_ready  = ready[0];
  assign bus.b_ready  = ready[1];
  assign bus.wen      = wen_q;
  assign bus.rd       = rd_q;
  assign bus.din      = din_q;
  assign bus.rs1_busy = hit1 && (bus.rs1 != '0);
  assign bus.rs2_busy = hit2 && (bus.rs2 != '0);
  assign bus.idle     = !nonempty[0] && !nonempty[1] && !wen_q;
endmodule
